// File: rtl/serial_pkg.sv
// Shared definitions for the serial data path blocks.
// Holds the collector FSM state encoding so that neighbouring serial
// stages decode the same values.
package serial_pkg;

  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

  typedef enum logic {
    ST_IDLE  = IDLE,
    ST_SHIFT = SHIFT
  } serial_state_e;

endpackage

// File: rtl/serial_word_collector_if.sv
// Bundle of the serial input side and the parallel valid/ready output side
// of the serial word collector.
interface serial_word_collector_if #(
  parameter int WIDTH = 8
);

  logic             bit_in;
  logic             bit_valid;
  logic             sof;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  // Collector side: consumes bits, produces words.
  modport slave (
    input  bit_in, bit_valid, sof, word_ready,
    output word_out, word_valid, busy, frame_err, overrun
  );

  // Environment side: drives bits, consumes words.
  modport master (
    output bit_in, bit_valid, sof, word_ready,
    input  word_out, word_valid, busy, frame_err, overrun
  );

endinterface

// File: rtl/swc_bit_counter.sv
// Bit position counter for the serial word collector.
// Counts accepted bits of the current word; terminal flags the bit that
// completes a word (the increment that would reach WIDTH, or a fresh
// start-of-word when a word is only one bit long). The count never
// reaches WIDTH because completion clears it in the same cycle.
module swc_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic load_one,
  input  logic inc,
  input  logic clr,
  output logic terminal
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] count_r;

  // Count register: clear has priority, then restart at one, then increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_r <= {CW{1'b0}};
    end else if (clr) begin
      count_r <= {CW{1'b0}};
    end else if (load_one) begin
      count_r <= CW'(1);
    end else if (inc) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Terminal detect for the bit that brings the count to WIDTH.
  always_comb begin
    terminal = 1'b0;
    if (inc && (count_r == CW'(WIDTH - 1))) begin
      terminal = 1'b1;
    end else if (load_one && (WIDTH == 1)) begin
      terminal = 1'b1;
    end else begin
      terminal = 1'b0;
    end
  end

endmodule

// File: rtl/serial_word_collector.sv
// Serial-to-parallel word collector.
// Aligns an LSB-first bit stream on the start-of-word marker, assembles
// WIDTH-bit words and hands them out on a valid/ready register, flagging
// aborted partial words (frame_err) and dropped complete words (overrun).
module serial_word_collector
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  serial_word_collector_if.slave  bus
);

  serial_state_e    state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shreg_next_s;
  logic [WIDTH-1:0] word_out_r;
  logic             word_valid_r;
  logic             busy_r;
  logic             frame_err_r;
  logic             overrun_r;
  logic             start_s;
  logic             inc_s;
  logic             complete_s;

  // Classify the incoming bit: start of a new word or continuation.
  always_comb begin
    start_s = bus.bit_valid & bus.sof;
    inc_s   = bus.bit_valid & ~bus.sof & (state_r == ST_SHIFT);
  end

  swc_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk      (clk),
    .rstn     (rstn),
    .load_one (start_s),
    .inc      (inc_s),
    .clr      (complete_s),
    .terminal (complete_s)
  );

  // Next shift register value: new bit enters at the MSB, so the first bit
  // ends up at bit 0 once WIDTH bits are in; a start drops the partial word.
  always_comb begin
    shreg_next_s = shreg_r;
    if (start_s) begin
      shreg_next_s = WIDTH'(bus.bit_in) << (WIDTH - 1);
    end else begin
      shreg_next_s = (shreg_r >> 1) | (WIDTH'(bus.bit_in) << (WIDTH - 1));
    end
  end

  // Shift register update on every accepted bit of a word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg_r <= {WIDTH{1'b0}};
    end else if (start_s || inc_s) begin
      shreg_r <= shreg_next_s;
    end else begin
      shreg_r <= shreg_r;
    end
  end

  // Collector FSM with registered busy and one-cycle frame error pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          frame_err_r <= 1'b0;
          if (start_s && !complete_s) begin
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          frame_err_r <= start_s;
          if (complete_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          frame_err_r <= 1'b0;
        end
      endcase
    end
  end

  // Output holding register: load on completion when free or being
  // consumed, otherwise drop the new word and record the overrun.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_out_r   <= {WIDTH{1'b0}};
      word_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (complete_s) begin
      if (!word_valid_r || bus.word_ready) begin
        word_out_r   <= shreg_next_s;
        word_valid_r <= 1'b1;
      end else begin
        overrun_r    <= 1'b1;
      end
    end else if (word_valid_r && bus.word_ready) begin
      word_valid_r <= 1'b0;
    end else begin
      word_valid_r <= word_valid_r;
    end
  end

  assign bus.word_out   = word_out_r;
  assign bus.word_valid = word_valid_r;
  assign bus.busy       = busy_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.overrun    = overrun_r;

endmodule
